// File: rtl/dcache_axi_bridge_if.sv
// AXI4 bus bundle between the dcache bridge (master) and the memory system (slave).
interface dcache_axi_bridge_if #(
    parameter int AXI_ID_W = 4
);
    logic [31:0]         araddr;
    logic [AXI_ID_W-1:0] arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [AXI_ID_W-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [31:0]         awaddr;
    logic [AXI_ID_W-1:0] awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [AXI_ID_W-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dcache_axi_bridge.sv
// dcache RAM-side port to AXI4: 4-beat refill bursts, and 4-beat writebacks through a
// single-entry line buffer; refills of the buffered line wait for its write response.
module dcache_axi_bridge #(
    parameter int AXI_ID_W = 4,
    parameter int RD_ID    = 0,
    parameter int WR_ID    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ram_rd_req_i,
    input  logic [31:0]          ram_rd_addr_i,
    output logic                 ram_rd_rdy_o,
    output logic [31:0]          ram_rd_data_o,
    output logic [2:0]           ram_rd_num_o,
    input  logic                 ram_wr_req_i,
    input  logic [31:0]          ram_wr_addr_i,
    input  logic [127:0]         ram_wr_data_i,
    input  logic                 ram_dirty_i,
    output logic                 ram_wr_rdy_o,
    dcache_axi_bridge_if.master  axi,
    output logic                 bus_err_o
);
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} r_state_e;

    w_state_e     w_state_q, w_state_d;
    logic [31:0]  waddr_q, waddr_d;
    logic [127:0] wbuf_q, wbuf_d;
    logic [1:0]   wcnt_q, wcnt_d;
    r_state_e     r_state_q, r_state_d;
    logic [31:0]  raddr_q, raddr_d;
    logic [1:0]   rcnt_q, rcnt_d;
    logic         rd_rdy_q, rd_rdy_d;
    logic [31:0]  rd_data_q, rd_data_d;
    logic [2:0]   rd_num_q, rd_num_d;
    logic         err_q, err_d;
    logic         w_err, r_err;
    logic         wr_accept, hazard;

    assign wr_accept = (w_state_q == W_IDLE) && ram_wr_req_i && ram_dirty_i;
    // A line entering the buffer this very cycle already blocks a refill of that line.
    assign hazard = ((w_state_q != W_IDLE) && (ram_rd_addr_i[31:4] == waddr_q[31:4])) ||
                    (wr_accept && (ram_rd_addr_i[31:4] == ram_wr_addr_i[31:4]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wbuf_q    <= '0;
            wcnt_q    <= '0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rd_rdy_q  <= 1'b0;
            rd_data_q <= '0;
            rd_num_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wbuf_q    <= wbuf_d;
            wcnt_q    <= wcnt_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            rd_rdy_q  <= rd_rdy_d;
            rd_data_q <= rd_data_d;
            rd_num_q  <= rd_num_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wbuf_d    = wbuf_q;
        wcnt_d    = wcnt_q;
        w_err     = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                // Clean lines are acknowledged by ram_wr_rdy_o and simply dropped.
                if (wr_accept) begin
                    waddr_d   = {ram_wr_addr_i[31:4], 4'b0};
                    wbuf_d    = ram_wr_data_i;
                    wcnt_d    = 2'd0;
                    w_state_d = W_AW;
                end
            end
            W_AW: if (axi.awready) w_state_d = W_DATA;
            W_DATA: begin
                if (axi.wready) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd3) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.bvalid) begin
                    w_err     = (axi.bresp != 2'b00);
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rcnt_d    = rcnt_q;
        rd_rdy_d  = 1'b0;
        rd_data_d = rd_data_q;
        rd_num_d  = rd_num_q;
        r_err     = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (ram_rd_req_i && !hazard) begin
                    raddr_d   = {ram_rd_addr_i[31:4], 4'b0};
                    rcnt_d    = 2'd0;
                    r_state_d = R_AR;
                end
            end
            R_AR: if (axi.arready) r_state_d = R_DATA;
            R_DATA: begin
                // The beat count, not rlast, ends the burst; a misplaced rlast only flags.
                if (axi.rvalid) begin
                    rd_rdy_d  = 1'b1;
                    rd_data_d = axi.rdata;
                    rd_num_d  = {1'b0, rcnt_q};
                    rcnt_d    = rcnt_q + 2'd1;
                    r_err     = (axi.rresp != 2'b00) || (axi.rlast != (rcnt_q == 2'd3));
                    if (rcnt_q == 2'd3) r_state_d = R_DONE;
                end
            end
            R_DONE: r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    assign err_d = err_q | w_err | r_err;

    assign ram_rd_rdy_o  = rd_rdy_q;
    assign ram_rd_data_o = rd_data_q;
    assign ram_rd_num_o  = rd_num_q;
    assign ram_wr_rdy_o  = (w_state_q == W_IDLE);
    assign bus_err_o     = err_q;

    assign axi.araddr  = raddr_q;
    assign axi.arid    = AXI_ID_W'(RD_ID);
    assign axi.arlen   = 8'd3;
    assign axi.arsize  = 3'd2;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = (r_state_q == R_AR);
    assign axi.rready  = (r_state_q == R_DATA);

    assign axi.awaddr  = waddr_q;
    assign axi.awid    = AXI_ID_W'(WR_ID);
    assign axi.awlen   = 8'd3;
    assign axi.awsize  = 3'd2;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = (w_state_q == W_AW);
    assign axi.wdata   = wbuf_q[{wcnt_q, 5'b0} +: 32];
    assign axi.wstrb   = 4'hF;
    assign axi.wlast   = (w_state_q == W_DATA) && (wcnt_q == 2'd3);
    assign axi.wvalid  = (w_state_q == W_DATA);
    assign axi.bready  = (w_state_q == W_RESP);

    logic unused_sigs;
    assign unused_sigs = ^{axi.rid, axi.bid, ram_rd_addr_i[3:0], ram_wr_addr_i[3:0]};
endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: refill, writeback, hazard, error and reset cases.
module tb_dcache_axi_bridge;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ram_rd_req = 1'b0;
    logic [31:0]  ram_rd_addr = '0;
    logic         ram_rd_rdy;
    logic [31:0]  ram_rd_data;
    logic [2:0]   ram_rd_num;
    logic         ram_wr_req = 1'b0;
    logic [31:0]  ram_wr_addr = '0;
    logic [127:0] ram_wr_data = '0;
    logic         ram_dirty = 1'b0;
    logic         ram_wr_rdy;
    logic         bus_err;

    always #5 clk = ~clk;

    dcache_axi_bridge_if #(.AXI_ID_W(4)) axi ();

    dcache_axi_bridge #(.AXI_ID_W(4), .RD_ID(0), .WR_ID(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ram_rd_req_i  (ram_rd_req),
        .ram_rd_addr_i (ram_rd_addr),
        .ram_rd_rdy_o  (ram_rd_rdy),
        .ram_rd_data_o (ram_rd_data),
        .ram_rd_num_o  (ram_rd_num),
        .ram_wr_req_i  (ram_wr_req),
        .ram_wr_addr_i (ram_wr_addr),
        .ram_wr_data_i (ram_wr_data),
        .ram_dirty_i   (ram_dirty),
        .ram_wr_rdy_o  (ram_wr_rdy),
        .axi           (axi.master),
        .bus_err_o     (bus_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ar_cnt = 0;
    int aw_cnt = 0;
    logic        b_done = 1'b0;
    logic [31:0] last_araddr = '0;
    logic [7:0]  last_arlen = '0;
    logic [2:0]  last_arsize = '0;
    logic [1:0]  last_arburst = '0;
    logic [3:0]  last_arid = '0;
    logic [31:0] last_awaddr = '0;
    logic [3:0]  last_awid = '0;

    int          rd_cyc_q[$];
    logic [2:0]  rd_num_q[$];
    logic [31:0] rd_dat_q[$];
    logic [31:0] wb_dat_q[$];
    logic        wb_last_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_rd_rdy) begin
            rd_cyc_q.push_back(cyc);
            rd_num_q.push_back(ram_rd_num);
            rd_dat_q.push_back(ram_rd_data);
        end
        if (axi.wvalid && axi.wready) begin
            wb_dat_q.push_back(axi.wdata);
            wb_last_q.push_back(axi.wlast);
        end
        if (axi.arvalid && axi.arready) begin
            last_araddr  <= axi.araddr;
            last_arlen   <= axi.arlen;
            last_arsize  <= axi.arsize;
            last_arburst <= axi.arburst;
            last_arid    <= axi.arid;
            ar_cnt       <= ar_cnt + 1;
        end
        if (axi.awvalid && axi.awready) begin
            last_awaddr <= axi.awaddr;
            last_awid   <= axi.awid;
            aw_cnt      <= aw_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_cyc_q.delete();
        rd_num_q.delete();
        rd_dat_q.delete();
        wb_dat_q.delete();
        wb_last_q.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] base,
                           input logic [7:0] resp_pat, input logic [3:0] last_pat);
        int k = 0;
        int n = 0;
        ram_rd_addr = addr;
        ram_rd_req  = 1'b1;
        axi.arready = 1'b1;
        while (n < 80) begin
            tick();
            n++;
            if (axi.arvalid) ram_rd_req = 1'b0;
            if (axi.rready && k < 4) begin
                axi.rvalid = 1'b1;
                axi.rdata  = base + 32'(k);
                axi.rresp  = resp_pat[2*k +: 2];
                axi.rlast  = last_pat[k];
                k++;
            end else begin
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
                axi.rresp  = 2'b00;
                if (k == 4) break;
            end
        end
        check_eq("rd_beats_issued", 64'(k), 64'd4);
        ram_rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_rd(input logic [31:0] base);
        check_eq("rd_count", 64'(rd_num_q.size()), 64'd4);
        for (int k = 0; k < rd_num_q.size() && k < 4; k++) begin
            check_eq("rd_num", 64'(rd_num_q[k]), 64'(k));
            check_eq("rd_data", 64'(rd_dat_q[k]), 64'(base + 32'(k)));
            check_eq("rd_consecutive", 64'(rd_cyc_q[k] - rd_cyc_q[0]), 64'(k));
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [127:0] data,
                            input int stall_beat, input int stall_n, input int b_delay,
                            input logic [1:0] bresp_v, output int d1_cycles);
        int beat  = 0;
        int stall = stall_n;
        int bwait = b_delay;
        int n     = 0;
        d1_cycles   = 0;
        b_done      = 1'b0;
        ram_wr_addr = addr;
        ram_wr_data = data;
        ram_dirty   = 1'b1;
        ram_wr_req  = 1'b1;
        axi.awready = 1'b1;
        tick();
        ram_wr_req = 1'b0;
        while (n < 100) begin
            if (axi.wvalid && axi.wdata == data[63:32]) d1_cycles++;
            if (axi.wvalid) begin
                if (beat == stall_beat && stall > 0) begin
                    axi.wready = 1'b0;
                    stall--;
                end else begin
                    axi.wready = 1'b1;
                    beat++;
                end
            end else begin
                axi.wready = 1'b0;
            end
            if (axi.bready) begin
                if (bwait > 0) begin
                    bwait--;
                    axi.bvalid = 1'b0;
                end else begin
                    axi.bvalid = 1'b1;
                    axi.bresp  = bresp_v;
                end
            end else begin
                axi.bvalid = 1'b0;
            end
            tick();
            n++;
            if (axi.bvalid) begin
                axi.bvalid = 1'b0;
                axi.bresp  = 2'b00;
                b_done     = 1'b1;
                break;
            end
        end
        axi.wready = 1'b0;
        check_eq("wr_b_done", 64'(b_done), 64'd1);
        check_eq("wr_rdy_after_b", 64'(ram_wr_rdy), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] wline;
        int d1;
        int viol;
        int n;
        int k;
        int aw_before;

        axi.arready = 1'b0;
        axi.rid     = '0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rvalid  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bid     = '0;
        axi.bresp   = 2'b00;
        axi.bvalid  = 1'b0;

        tick();
        tick();
        check_eq("rst_wr_rdy", 64'(ram_wr_rdy), 64'd1);
        check_eq("rst_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, ram_rd_rdy}), 64'd0);
        check_eq("rst_bus_err", 64'(bus_err), 64'd0);
        check_eq("rst_addr", 64'({axi.araddr, axi.awaddr}), 64'd0);
        check_eq("rst_data", 64'({axi.wdata, ram_rd_data}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Plain refill
        clear_mon();
        do_read(32'h0000_1234, 32'h0000_00A0, 8'h00, 4'b1000);
        check_eq("refill_araddr", 64'(last_araddr), 64'h0000_1230);
        check_eq("refill_arlen", 64'(last_arlen), 64'd3);
        check_eq("refill_arsize_burst_id", 64'({last_arsize, last_arburst, last_arid}), 64'({3'd2, 2'b01, 4'd0}));
        check_rd(32'h0000_00A0);
        check_eq("refill_no_err", 64'(bus_err), 64'd0);

        // Writeback with a 2-cycle W stall on beat 1
        clear_mon();
        wline = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
        do_write(32'h0000_2000, wline, 1, 2, 0, 2'b00, d1);
        check_eq("wb_awaddr", 64'(last_awaddr), 64'h0000_2000);
        check_eq("wb_awid", 64'(last_awid), 64'd1);
        check_eq("wb_beats", 64'(wb_dat_q.size()), 64'd4);
        for (int i = 0; i < wb_dat_q.size() && i < 4; i++) begin
            check_eq("wb_wdata", 64'(wb_dat_q[i]), 64'(wline[32*i +: 32]));
            check_eq("wb_wlast", 64'(wb_last_q[i]), 64'(i == 3));
        end
        check_eq("wb_d1_held", 64'(d1), 64'd3);
        check_eq("wb_no_err", 64'(bus_err), 64'd0);

        // Clean line: acknowledged, no bus activity
        aw_before   = aw_cnt;
        ram_wr_addr = 32'h0000_2800;
        ram_dirty   = 1'b0;
        ram_wr_req  = 1'b1;
        tick();
        check_eq("clean_wr_rdy", 64'(ram_wr_rdy), 64'd1);
        ram_wr_req = 1'b0;
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (axi.awvalid || axi.wvalid || !ram_wr_rdy) viol++;
        end
        check_eq("clean_no_activity", 64'(viol), 64'd0);
        check_eq("clean_no_aw", 64'(aw_cnt - aw_before), 64'd0);

        // Same-line read must wait for the write response
        clear_mon();
        fork
            do_write(32'h0000_3000, {4{32'h5555_AAAA}}, 9, 0, 12, 2'b00, d1);
            begin
                ram_rd_addr = 32'h0000_3008;
                ram_rd_req  = 1'b1;
                viol = 0;
                n = 0;
                while (!b_done && n < 100) begin
                    tick();
                    if (axi.arvalid && !b_done) viol++;
                    n++;
                end
                check_eq("haz_ar_blocked", 64'(viol), 64'd0);
                do_read(32'h0000_3008, 32'h0000_00B0, 8'h00, 4'b1000);
            end
        join
        check_eq("haz_araddr", 64'(last_araddr), 64'h0000_3000);
        check_rd(32'h0000_00B0);

        // Different-line read overlaps a pending writeback
        clear_mon();
        fork
            do_write(32'h0000_3000, {4{32'h1234_5678}}, 9, 0, 25, 2'b00, d1);
            begin
                tick();
                do_read(32'h0000_4000, 32'h0000_00C0, 8'h00, 4'b1000);
                check_eq("ovl_rd_before_b", 64'(b_done), 64'd0);
            end
        join
        check_eq("ovl_araddr", 64'(last_araddr), 64'h0000_4000);
        check_rd(32'h0000_00C0);
        check_eq("ovl_no_err", 64'(bus_err), 64'd0);

        // SLVERR on beat 2
        clear_mon();
        do_read(32'h0000_5000, 32'h0000_00D0, 8'h20, 4'b1000);
        check_rd(32'h0000_00D0);
        check_eq("rresp_err", 64'(bus_err), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        check_eq("rresp_err_sticky", 64'(bus_err), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("err_cleared_by_rst", 64'(bus_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Early rlast on beat 1
        clear_mon();
        do_read(32'h0000_5100, 32'h0000_00E0, 8'h00, 4'b1010);
        check_rd(32'h0000_00E0);
        check_eq("rlast_err", 64'(bus_err), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a refill burst
        clear_mon();
        ram_rd_addr = 32'h0000_6000;
        ram_rd_req  = 1'b1;
        axi.arready = 1'b1;
        k = 0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (axi.arvalid) ram_rd_req = 1'b0;
            if (axi.rready && k < 2) begin
                axi.rvalid = 1'b1;
                axi.rdata  = 32'h0000_00F0 + 32'(k);
                axi.rresp  = 2'b00;
                axi.rlast  = 1'b0;
                k++;
            end else if (k == 2) begin
                break;
            end
        end
        axi.rvalid = 1'b0;
        check_eq("midrst_beats", 64'(k), 64'd2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, ram_rd_rdy}), 64'd0);
        check_eq("midrst_wr_rdy", 64'(ram_wr_rdy), 64'd1);
        check_eq("midrst_addr", 64'(axi.araddr), 64'd0);
        check_eq("midrst_pre_strobes", 64'(rd_num_q.size()), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        do_read(32'h0000_7000, 32'h0000_0070, 8'h00, 4'b1000);
        check_eq("postrst_araddr", 64'(last_araddr), 64'h0000_7000);
        check_rd(32'h0000_0070);
        check_eq("postrst_no_err", 64'(bus_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
